map_param_ram: RTL
==================

# map_param_ram

Parametrised single-clock RAM with registered input and output stages, per-byte write enables, a selectable write-read output mode and a built-in clear sequencer that fills the array with a constant after reset or on demand. It is the next-generation replacement for our fixed 16×256 registered-I/O RAM macro wrappers. It sits between datapath masters and on-chip storage wherever a table needs a known power-up state without an initialisation file.

## Interface
Parameters:
- DATA_W, 16, word width; must be a multiple of 8.
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- WRITE_THRU, 1, write-op output: 1 = merged new word, 0 = old word (read-before-write).
- INIT_VAL, 0, word written to every location by the clear sweep.

Ports:
- clk, in, 1, single clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req, in, 1, operation request, sampled at the rising edge.
- we, in, 1, 1 = write, 0 = read; qualified by req.
- addr, in, ADDR_W, word address.
- datain, in, DATA_W, write data.
- be, in, DATA_W/8, byte enables; bit i selects datain[8i+7:8i]. Ignored for reads.
- clear, in, 1, 1-cycle pulse that starts a clear sweep.
- dataout, out, DATA_W, registered read or response data.
- rvalid, out, 1, dataout valid for one cycle for each accepted op.
- busy, out, 1, clear sweep in progress; req is not accepted.

## Operation
- FSM states:
  - ST_INIT: sweeps the clear counter from 0 to 2**ADDR_W-1 and writes INIT_VAL to one word per cycle.
  - ST_IDLE: accepts req.
- Transitions:
  - Reset drives the FSM to ST_INIT with counter 0.
  - ST_INIT→ST_IDLE after the write to the last address.
  - ST_IDLE→ST_INIT when clear=1; counter set to 0.
  - clear during ST_INIT restarts the sweep at 0.
- busy=1 exactly while in ST_INIT.
- A req sampled while busy=1 is dropped: no array access, no rvalid.
- Read: dataout = stored word.
- Write: only the bytes with be=1 are updated. be=0 on a write leaves the array unchanged but still returns a response.
- Write response on dataout:
  - WRITE_THRU=1: the merged word, old bytes where be=0 and datain bytes where be=1.
  - WRITE_THRU=0: the pre-write word.
- Ops already in the pipeline when clear is asserted complete normally. Their rvalid and dataout still appear.
- One op per cycle. A back-to-back write then read to the same address returns the written data; no stall.

## Timing
- Stage 1: input register captures req, we, addr, datain and be at edge k.
- Stage 2: array access at edge k+1; the write commits and the old word is read.
- Output: the output register loads at edge k+2. rvalid=1 and dataout are valid during the cycle after edge k+2.
- Latency: 2 cycles from the sampling edge to the response, for reads and writes. Throughput: 1 op per cycle.
- Clear sweep length: 2**ADDR_W cycles. busy deasserts in the cycle after the last sweep write. The first accepted req is at the edge where busy is sampled 0.
- Reset values:
  - busy=1 (sweep starts immediately).
  - rvalid=0; dataout=0.
  - All pipeline valid bits are 0; FSM = ST_INIT with counter 0.
- rst_n asserted mid-operation: in-flight ops are discarded, no rvalid is produced, and the sweep restarts. Array contents are undefined until that sweep completes.

## Structure
- Shared package map_ram_pkg holds:
  - the state enum (ST_INIT, ST_IDLE);
  - the WRITE_THRU mode constants (WT_NEW=1, WT_OLD=0);
  - a byte-merge function for (old, new, be).
- Sub-module ram_core contains the plain synchronous array: one address, byte-enable write, read-old-data port, no reset.
- Sweep writes enter ram_core through the same port, muxed by busy.

## Test plan
- Reset, then release rst_n: busy stays 1 for 256 cycles. Reads of addr 0x00, 0x7F and 0xFF then return 0x0000 with rvalid 2 cycles after each req.
- Write 0xBEEF to 0x10 with be=2'b11, then read 0x10 on the next cycle: the read returns 0xBEEF 2 cycles after its req.
- Write 0x1234 to 0x20 with be=2'b11, then write 0xAB00 with be=2'b10:
  - WRITE_THRU=1: the second response is 0xAB34 and a later read returns 0xAB34.
  - WRITE_THRU=0: the second response is 0x1234.
- Stream 256 consecutive reads with req held high: rvalid stays high for 256 cycles with no gaps, and the data matches the expected contents.
- Pulse clear with INIT_VAL=0x5A5A while two reads are in flight: both reads complete with their old data. busy then rises for 256 cycles, reqs issued during busy produce no rvalid, and a later read returns 0x5A5A.
- Assert rst_n low for 1 cycle at sweep count 100, and separately during a pending read: the pending read produces no rvalid, and the sweep restarts from 0 for a full 256 cycles.

Source files
------------

// File: rtl/map_ram_pkg.sv
// -----------------------------------------------------------------------------
// map_ram_pkg
// Shared definitions for map_param_ram and its storage core:
//   - state_t     : clear-sequencer states (ST_INIT sweeps, ST_IDLE serves ops)
//   - WT_NEW/WT_OLD : values for the WRITE_THRU parameter
//   - byte_merge  : combines an old word with new data under byte enables
// -----------------------------------------------------------------------------
package map_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Write response selection.
  localparam int WT_NEW = 1;  // respond with the merged (post-write) word
  localparam int WT_OLD = 0;  // respond with the pre-write word

  // Widest word byte_merge handles; callers zero-extend in and truncate out.
  localparam int MERGE_W    = 512;
  localparam int MERGE_BE_W = MERGE_W / 8;

  // Byte i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_w,
    input logic [MERGE_W-1:0]    new_w,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/map_param_ram_core.sv
// -----------------------------------------------------------------------------
// ram_core
// Plain single-port synchronous array with per-byte write enables. The read
// port returns the word stored before any write at the same edge.
// Ports:
//   clk      : rising-edge clock
//   i_we     : write strobe
//   i_be     : byte enables, bit i selects i_wdata[8i+7:8i]
//   i_addr   : word address (read and write share it)
//   i_wdata  : write data
//   o_rdata  : registered read data (old word)
// -----------------------------------------------------------------------------
module ram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; a reset would prevent mapping onto RAM
  // macros. Its power-up contents are established by the clear sweep.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read below see the pre-write
    // word, which is exactly the read-old-data behaviour this port promises.
    o_rdata <= r_mem[i_addr];
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/map_param_ram.sv
// -----------------------------------------------------------------------------
// map_param_ram
// Registered-I/O RAM with byte enables, selectable write response and a clear
// sequencer that fills every word with INIT_VAL after reset or on clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req, we    : op request (sampled at rising edge), 1 = write / 0 = read
//   addr       : word address
//   datain, be : write data and byte enables (be ignored on reads)
//   clear      : one-cycle pulse starting (or restarting) a clear sweep
//   dataout    : response data, valid while rvalid = 1
//   rvalid     : one cycle per accepted op, two cycles after it was sampled
//   busy       : sweep in progress; req is dropped while high
// Pipeline: edge k captures the op, edge k+1 accesses the array, edge k+2
// loads dataout/rvalid.
// -----------------------------------------------------------------------------
module map_param_ram
  import map_ram_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 8,
  parameter int                WRITE_THRU = WT_NEW,
  parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   datain,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clear,
  output logic [DATA_W-1:0]   dataout,
  output logic                rvalid,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  // Sequencer state.
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;

  // Stage 1 (captured op) and stage 2 (op whose array access has happened).
  logic              r_s1_valid, r_s2_valid;
  logic              r_s1_we, r_s2_we;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data, r_s2_data;
  logic [NB-1:0]     r_s1_be, r_s2_be;

  // Array port.
  logic              w_sweep_wr;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [NB-1:0]     w_ram_be;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_resp;

  assign busy = (r_state == ST_INIT);

  // An op captured in the same edge that starts a sweep still owns the port
  // on the following edge; the sweep waits that one cycle so the op completes
  // against the pre-clear contents.
  assign w_sweep_wr  = busy && !r_s1_valid;
  assign w_ram_we    = w_sweep_wr || (r_s1_valid && r_s1_we);
  assign w_ram_addr  = w_sweep_wr ? r_cnt    : r_s1_addr;
  assign w_ram_be    = w_sweep_wr ? '1       : r_s1_be;
  assign w_ram_wdata = w_sweep_wr ? INIT_VAL : r_s1_data;

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Next-state logic for the clear sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (clear) begin
          w_cnt_nxt = '0;
        end else if (w_sweep_wr) begin
          if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_IDLE;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Write response: merged word in write-through mode, otherwise the old word
  // (reads always return the old word).
  always_comb begin
    w_resp = w_ram_rdata;
    if (r_s2_we && (WRITE_THRU == WT_NEW)) begin
      w_resp = DATA_W'(byte_merge(MERGE_W'(w_ram_rdata), MERGE_W'(r_s2_data),
                                  MERGE_BE_W'(r_s2_be)));
    end
  end

  // Valid bits and outputs: cleared by reset so in-flight ops are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      rvalid     <= 1'b0;
      dataout    <= '0;
    end else begin
      r_s1_valid <= req && !busy;
      r_s2_valid <= r_s1_valid;
      rvalid     <= r_s2_valid;
      if (r_s2_valid) dataout <= w_resp;
    end
  end

  // Payload registers carry no reset; they are only consumed under a valid bit.
  always_ff @(posedge clk) begin
    r_s1_we   <= we;
    r_s1_addr <= addr;
    r_s1_data <= datain;
    r_s1_be   <= be;
    r_s2_we   <= r_s1_we;
    r_s2_data <= r_s1_data;
    r_s2_be   <= r_s1_be;
  end

endmodule
